// File: rtl/display_mode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the display mode controller.
//   MODE_NORMAL / MODE_DISPLAY : legacy two-mode names (mode 0 / mode 1)
//   DEF_NUM_MODES              : default mode count (legacy toggle behaviour)
//   mode_t                     : encoded mode type sized for the default count
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int MODE_NORMAL   = 0;
   localparam int MODE_DISPLAY  = 1;
   localparam int DEF_NUM_MODES = 2;
   localparam int DEF_MODE_W    = $clog2(DEF_NUM_MODES);

   typedef logic [DEF_MODE_W-1:0] mode_t;

endpackage

// File: rtl/display_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_mode_if
// Bundles the button levels, timeout gate and mode outputs of the controller.
//   master : button/debouncer side (drives sig_next/sig_prev/sig_home/timeout_en)
//   slave  : controller side (drives mode/mode_onehot/changed)
// -----------------------------------------------------------------------------
interface display_mode_if #(
   parameter int NUM_MODES = display_pkg::DEF_NUM_MODES,
   parameter int MODE_W    = $clog2(NUM_MODES)
);

   logic                 sig_next;
   logic                 sig_prev;
   logic                 sig_home;
   logic                 timeout_en;
   logic [MODE_W-1:0]    mode;
   logic [NUM_MODES-1:0] mode_onehot;
   logic                 changed;

   modport master (
      output sig_next, sig_prev, sig_home, timeout_en,
      input  mode, mode_onehot, changed
   );

   modport slave (
      input  sig_next, sig_prev, sig_home, timeout_en,
      output mode, mode_onehot, changed
   );

endinterface

// File: rtl/display_mode_ctrl_edge_rise_det.sv
// -----------------------------------------------------------------------------
// edge_rise_det
// Single-cycle rising-edge detector on a synchronous level.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   in_i    : input level
//   pulse_o : high while in_i is 1 and was 0 at the previous clock edge
// History resets to 1 so a level already high at reset release is not an edge.
// -----------------------------------------------------------------------------
module edge_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic in_i,
   output logic pulse_o
);

   logic hist_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= 1'b1;
      end else begin
         hist_q <= in_i;
      end
   end

   assign pulse_o = in_i & ~hist_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// -----------------------------------------------------------------------------
// display_mode_ctrl
// Steps through NUM_MODES display modes on button edges, with direct return to
// mode 0 and an optional idle timeout back to mode 0.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : display_mode_if.slave
//          in : sig_next, sig_prev, sig_home (levels), timeout_en
//          out: mode (encoded), mode_onehot, changed (1-cycle pulse on new mode)
// -----------------------------------------------------------------------------
module display_mode_ctrl
   import display_pkg::*;
#(
   parameter int NUM_MODES   = DEF_NUM_MODES,
   parameter int MODE_W      = $clog2(NUM_MODES),
   parameter int RESET_MODE  = 0,
   parameter int TIMEOUT_CYC = 0,
   parameter int CNT_W       = 32
) (
   input logic           clk,
   input logic           rst,
   display_mode_if.slave bus
);

   localparam logic [MODE_W-1:0] M_ZERO  = MODE_W'(MODE_NORMAL);
   localparam logic [MODE_W-1:0] M_LAST  = MODE_W'(NUM_MODES - 1);
   localparam logic [MODE_W-1:0] M_RESET = MODE_W'(RESET_MODE);
   localparam bit                TO_ON   = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0]  EXP_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic              ev_next, ev_prev, ev_home, ev_any;
   logic              expire;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [CNT_W-1:0]  idle_q, idle_d;
   logic              changed_q;

   edge_rise_det u_det_next (.clk(clk), .rst(rst), .in_i(bus.sig_next), .pulse_o(ev_next));
   edge_rise_det u_det_prev (.clk(clk), .rst(rst), .in_i(bus.sig_prev), .pulse_o(ev_prev));
   edge_rise_det u_det_home (.clk(clk), .rst(rst), .in_i(bus.sig_home), .pulse_o(ev_home));

   // A cancelled next+prev pair still counts as activity for the idle counter.
   assign ev_any = ev_next | ev_prev | ev_home;

   always_comb begin
      expire = TO_ON && bus.timeout_en && (mode_q != M_ZERO) &&
               (idle_q == EXP_CNT) && !ev_any;

      mode_d = mode_q;
      if (ev_home) begin
         mode_d = M_ZERO;
      end else if (ev_next && ev_prev) begin
         mode_d = mode_q;
      end else if (ev_next) begin
         // Wrap by compare so non-power-of-two mode counts never overflow.
         mode_d = (mode_q == M_LAST) ? M_ZERO : mode_q + MODE_W'(1);
      end else if (ev_prev) begin
         mode_d = (mode_q == M_ZERO) ? M_LAST : mode_q - MODE_W'(1);
      end else if (expire) begin
         mode_d = M_ZERO;
      end

      if (ev_any || expire || (mode_q == M_ZERO) || !bus.timeout_en || !TO_ON) begin
         idle_d = '0;
      end else if (idle_q == {CNT_W{1'b1}}) begin
         idle_d = idle_q;
      end else begin
         idle_d = idle_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q    <= M_RESET;
         idle_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         idle_q    <= idle_d;
         changed_q <= (mode_d != mode_q);
      end
   end

   always_comb begin
      bus.mode_onehot = '0;
      for (int i = 0; i < NUM_MODES; i++) begin
         bus.mode_onehot[i] = (mode_q == MODE_W'(i));
      end
   end

   assign bus.mode    = mode_q;
   assign bus.changed = changed_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_mode_ctrl
// Bench for display_mode_ctrl: a 4-mode instance with a 10-cycle timeout and a
// 2-mode legacy-toggle instance, checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_display_mode_ctrl;

   logic clk;
   logic rst_n;

   logic nx [2];
   logic pv [2];
   logic hm [2];
   logic te [2];

   display_mode_if #(.NUM_MODES(4)) if_a ();
   display_mode_if #(.NUM_MODES(2)) if_b ();

   assign if_a.sig_next   = nx[0];
   assign if_a.sig_prev   = pv[0];
   assign if_a.sig_home   = hm[0];
   assign if_a.timeout_en = te[0];
   assign if_b.sig_next   = nx[1];
   assign if_b.sig_prev   = pv[1];
   assign if_b.sig_home   = hm[1];
   assign if_b.timeout_en = te[1];

   display_mode_ctrl #(.NUM_MODES(4), .RESET_MODE(0), .TIMEOUT_CYC(10), .CNT_W(32)) u_a (
      .clk(clk), .rst(rst_n), .bus(if_a.slave)
   );

   display_mode_ctrl #(.NUM_MODES(2), .RESET_MODE(0), .TIMEOUT_CYC(0), .CNT_W(32)) u_b (
      .clk(clk), .rst(rst_n), .bus(if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // Reference model state: mode number, cycles idle, last-seen input levels.
   int nmodes [2];
   int tocyc  [2];
   int mm     [2];
   int idle   [2];
   int pn     [2];
   int pp     [2];
   int ph     [2];
   int mch    [2];

   typedef struct {
      bit n;
      bit p;
      bit h;
      int exp_mode;
      bit exp_ch;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mm[d]   = 0;
         idle[d] = 0;
         pn[d]   = 1;
         pp[d]   = 1;
         ph[d]   = 1;
         mch[d]  = 0;
      end
   endtask

   task automatic model_edge(input int d);
      int en, ep, eh, old, nm, fire;
      en = (nx[d] == 1'b1 && pn[d] == 0) ? 1 : 0;
      ep = (pv[d] == 1'b1 && pp[d] == 0) ? 1 : 0;
      eh = (hm[d] == 1'b1 && ph[d] == 0) ? 1 : 0;
      pn[d] = int'(nx[d]);
      pp[d] = int'(pv[d]);
      ph[d] = int'(hm[d]);
      old  = mm[d];
      fire = 0;
      if (eh != 0)                 nm = 0;
      else if (en != 0 && ep != 0) nm = old;
      else if (en != 0)            nm = (old + 1) % nmodes[d];
      else if (ep != 0)            nm = (old + nmodes[d] - 1) % nmodes[d];
      else begin
         nm = old;
         if (tocyc[d] != 0 && te[d] == 1'b1 && old != 0 && idle[d] == tocyc[d] - 1) begin
            nm   = 0;
            fire = 1;
         end
      end
      if (en != 0 || ep != 0 || eh != 0 || fire != 0 || old == 0 || te[d] == 1'b0 || tocyc[d] == 0)
         idle[d] = 0;
      else
         idle[d] = idle[d] + 1;
      mch[d] = (nm != old) ? 1 : 0;
      mm[d]  = nm;
   endtask

   task automatic check_all();
      chk("a_mode",    int'(if_a.mode),        mm[0]);
      chk("a_onehot",  int'(if_a.mode_onehot), 1 << mm[0]);
      chk("a_changed", int'(if_a.changed),     mch[0]);
      chk("b_mode",    int'(if_b.mode),        mm[1]);
      chk("b_onehot",  int'(if_b.mode_onehot), 1 << mm[1]);
      chk("b_changed", int'(if_b.changed),     mch[1]);
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n == 1'b1) begin
         model_edge(0);
         model_edge(1);
      end
      #1;
      check_all();
   endtask

   task automatic press_next_a();
      nx[0] = 1'b1; step();
      nx[0] = 1'b0; step();
   endtask

   task automatic press_home_a();
      hm[0] = 1'b1; step();
      hm[0] = 1'b0; step();
   endtask

   int k;
   int b_before;
   int quiet;
   int oh_exp [4];

   initial begin
      nmodes[0] = 4;  tocyc[0] = 10;
      nmodes[1] = 2;  tocyc[1] = 0;
      for (int d = 0; d < 2; d++) begin
         nx[d] = 1'b1; pv[d] = 1'b0; hm[d] = 1'b0; te[d] = 1'b0;
      end

      //            n  p  h  mode ch
      tbl[0]  = '{0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 1, 1};
      tbl[2]  = '{0, 0, 0, 1, 0};
      tbl[3]  = '{1, 0, 0, 2, 1};
      tbl[4]  = '{0, 0, 0, 2, 0};
      tbl[5]  = '{1, 1, 0, 2, 0};
      tbl[6]  = '{0, 0, 0, 2, 0};
      tbl[7]  = '{1, 0, 1, 0, 1};
      tbl[8]  = '{0, 0, 0, 0, 0};
      tbl[9]  = '{0, 1, 0, 3, 1};
      tbl[10] = '{0, 0, 0, 3, 0};
      tbl[11] = '{0, 0, 1, 0, 1};
      tbl[12] = '{0, 0, 1, 0, 0};
      tbl[13] = '{0, 0, 0, 0, 0};
      tbl[14] = '{0, 0, 1, 0, 0};
      tbl[15] = '{0, 0, 0, 0, 0};

      oh_exp[0] = 2; oh_exp[1] = 4; oh_exp[2] = 8; oh_exp[3] = 1;

      // Reset with sig_next held high: no event on release.
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_mode",    int'(if_a.mode),        0);
      chk("rst_onehot",  int'(if_a.mode_onehot), 1);
      chk("rst_changed", int'(if_a.changed),     0);
      rst_n = 1'b1;
      step();
      step();
      chk("held_next_mode", int'(if_a.mode), 0);
      chk("held_next_chg",  int'(if_a.changed), 0);
      nx[0] = 1'b0; nx[1] = 1'b0; step();
      nx[0] = 1'b1; step();
      chk("first_press_mode", int'(if_a.mode), 1);
      chk("first_press_chg",  int'(if_a.changed), 1);
      nx[0] = 1'b0; step();
      chk("first_press_chg_end", int'(if_a.changed), 0);
      press_home_a();

      // Table: priority, cancel, home, wrap (timeout disabled).
      for (int i = 0; i < 16; i++) begin
         nx[0] = tbl[i].n; pv[0] = tbl[i].p; hm[0] = tbl[i].h;
         nx[1] = tbl[i].n;
         step();
         chk($sformatf("tbl%0d_mode", i), int'(if_a.mode), tbl[i].exp_mode);
         chk($sformatf("tbl%0d_chg", i),  int'(if_a.changed), int'(tbl[i].exp_ch));
      end

      // Four next presses, then prev from 0.
      for (int i = 0; i < 4; i++) begin
         nx[0] = 1'b1; step();
         chk($sformatf("cycle%0d_onehot", i), int'(if_a.mode_onehot), oh_exp[i]);
         nx[0] = 1'b0; step();
      end
      pv[0] = 1'b1; step();
      chk("prev_wrap_mode", int'(if_a.mode), 3);
      pv[0] = 1'b0; step();

      // Timeout: mode 0 exactly 10 clocks after the last event.
      press_home_a();
      te[0] = 1'b1;
      press_next_a();
      press_next_a();
      k = 1;
      while (k < 10) begin
         if (k > 1) step();
         chk("to_hold_mode", int'(if_a.mode), 2);
         k++;
      end
      step();
      chk("to_expire_mode", int'(if_a.mode), 0);
      chk("to_expire_chg",  int'(if_a.changed), 1);
      step();
      chk("to_expire_chg_end", int'(if_a.changed), 0);

      // Event on the expiry cycle wins and restarts the count.
      press_next_a();
      press_next_a();
      for (int i = 2; i <= 9; i++) step();
      nx[0] = 1'b1; step();
      chk("exp_press_mode", int'(if_a.mode), 3);
      chk("exp_press_chg",  int'(if_a.changed), 1);
      nx[0] = 1'b0; step();
      for (int i = 2; i <= 9; i++) step();
      chk("restart_hold_mode", int'(if_a.mode), 3);
      step();
      chk("restart_expire_mode", int'(if_a.mode), 0);

      // Timeout gated off.
      press_next_a();
      press_next_a();
      te[0] = 1'b0;
      repeat (30) step();
      chk("gated_mode", int'(if_a.mode), 2);
      te[0] = 1'b1;

      // Asynchronous reset mid-count in mode 3 with sig_prev held.
      press_home_a();
      pv[0] = 1'b1; step();
      chk("pre_rst_mode", int'(if_a.mode), 3);
      repeat (4) step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_mode",    int'(if_a.mode), 0);
      chk("async_rst_onehot",  int'(if_a.mode_onehot), 1);
      chk("async_rst_changed", int'(if_a.changed), 0);
      chk("async_rst_idle",    int'(u_a.idle_q), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("held_prev_mode", int'(if_a.mode), 0);
      step();
      pv[0] = 1'b0; step();
      pv[0] = 1'b1; step();
      chk("reprs_prev_mode", int'(if_a.mode), 3);
      pv[0] = 1'b0; step();

      // Legacy toggle: held sig_next gives a single toggle.
      nx[1] = 1'b0; step();
      b_before = mm[1];
      nx[1] = 1'b1; step();
      chk("legacy_toggle", int'(if_b.mode), 1 - b_before);
      repeat (49) step();
      chk("legacy_held", int'(if_b.mode), 1 - b_before);
      nx[1] = 1'b0; step();
      nx[1] = 1'b1; step();
      chk("legacy_toggle_back", int'(if_b.mode), b_before);

      // Randomized traffic with quiet stretches so timeouts can fire.
      quiet = 0;
      for (int c = 0; c < 800; c++) begin
         if (quiet > 0) begin
            quiet--;
         end else begin
            for (int d = 0; d < 2; d++) begin
               if ($urandom_range(0, 3) == 0) nx[d] = ~nx[d];
               if ($urandom_range(0, 3) == 0) pv[d] = ~pv[d];
               if ($urandom_range(0, 9) == 0) hm[d] = ~hm[d];
               if ($urandom_range(0, 39) == 0) te[d] = ~te[d];
            end
            if ($urandom_range(0, 11) == 0) quiet = int'($urandom_range(8, 14));
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
